// File: rtl/piso_shift_tx_if.sv
// rtl/piso_shift_tx_if.sv - load handshake and serial output bundle for piso_shift_tx
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in/serial-out shift transmitter (optional trailing parity bit via PISO_PARITY_EN)
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  piso_shift_tx_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             head;
  logic             capture;
  logic             advance;
  logic             finish;
  logic             ready_c;
  logic             sout_c;
  logic             sout_valid_c;
  logic             busy_c;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  // The bit on the line is always the register head; shifting moves the next bit into it.
  assign head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_nxt    = state;
    ready_c      = 1'b0;
    sout_c       = 1'b0;
    sout_valid_c = 1'b0;
    busy_c       = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.load_valid) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sout_c       = head;
        sout_valid_c = 1'b1;
        busy_c       = 1'b1;
        if (bus.shift_en) begin
          advance = 1'b1;
          if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            finish    = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_c       = par_q;
        sout_valid_c = 1'b1;
        busy_c       = 1'b1;
        if (bus.shift_en) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and the registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (capture) begin
        sreg <= bus.load_data;
        cnt  <= '0;
      end else if (advance) begin
        sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        // Wrap to zero on the last bit so the counter never leaves 0..WIDTH-1.
        cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

`ifdef PISO_PARITY_EN
  // Even parity of the word is fixed at capture time, independent of later load_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         par_q <= 1'b0;
    else if (capture) par_q <= ^bus.load_data;
  end
`endif

  assign bus.load_ready = ready_c;
  assign bus.sout       = sout_c;
  assign bus.sout_valid = sout_valid_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - scoreboard bench for piso_shift_tx, MSB-first and LSB-first instances side by side
module tb_piso_shift_tx;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   q_m[$];
  bit   q_l[$];

  piso_shift_tx_if #(.WIDTH(WIDTH)) mb ();
  piso_shift_tx_if #(.WIDTH(WIDTH)) lb ();

  assign lb.load_valid = mb.load_valid;
  assign lb.load_data  = mb.load_data;
  assign lb.shift_en   = mb.shift_en;

  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(mb));
  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(lb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) q_m.push_back(w[i]);
    for (int i = 0; i < WIDTH; i++) q_l.push_back(w[i]);
    if (PAR != 0) begin
      q_m.push_back(^w);
      q_l.push_back(^w);
    end
  endtask

  // Drive a load in a cycle where the DUT is idle; returns just after the handshake edge.
  task automatic start_word(input logic [WIDTH-1:0] w);
    mb.load_valid = 1'b1;
    mb.load_data  = w;
    mb.shift_en   = 1'b1;
    push_expected(w);
    @(posedge clk);
    #1;
  endtask

  // Follow one word to its done cycle; shift_en is low for hold_n cycles after bit hold_at-1.
  task automatic track(input int hold_at, input int hold_n, input bit spam);
    int exp_done;
    exp_done = WIDTH + 1 + hold_n + PAR;
    mb.load_valid = spam;
    mb.load_data  = spam ? 8'hFF : 8'h5A;
    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      mb.shift_en = !(cyc > hold_at && cyc <= hold_at + hold_n);
      @(negedge clk);
      check("done_m", mb.done, cyc == exp_done);
      check("done_l", lb.done, cyc == exp_done);
      check("ready", mb.load_ready, cyc == exp_done);
      check("busy", mb.busy, cyc != exp_done);
      if (cyc != exp_done) begin
        @(posedge clk);
        #1;
      end
    end
    mb.shift_en = 1'b1;
  endtask

  task automatic idle(input int n);
    mb.load_valid = 1'b0;
    mb.shift_en   = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("done_clr", mb.done, 1'b0);
      check("idle_ready", mb.load_ready, 1'b1);
      check("idle_busy", mb.busy, 1'b0);
    end
  endtask

  // Scoreboard: every valid serial bit is compared against the queue head; it is consumed on enabled edges.
  always @(negedge clk) begin
    if (rst) begin
      if (mb.sout_valid) begin
        if (q_m.size() == 0) check("m_extra", q_m.size(), 1);
        else begin
          check("m_sout", mb.sout, q_m[0]);
          if (mb.shift_en) void'(q_m.pop_front());
        end
      end else check("m_idle_sout", mb.sout, 1'b0);
      if (lb.sout_valid) begin
        if (q_l.size() == 0) check("l_extra", q_l.size(), 1);
        else begin
          check("l_sout", lb.sout, q_l[0]);
          if (lb.shift_en) void'(q_l.pop_front());
        end
      end else check("l_idle_sout", lb.sout, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    mb.load_valid = 1'b0;
    mb.load_data  = '0;
    mb.shift_en   = 1'b0;
    #3;
    rst = 1'b0;
    #2;
    check("rst_sout", mb.sout, 1'b0);
    check("rst_valid", mb.sout_valid, 1'b0);
    check("rst_busy", mb.busy, 1'b0);
    check("rst_done", mb.done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", mb.load_ready, 1'b1);
    check("rst_ready_l", lb.load_ready, 1'b1);

    start_word(8'hA5); track(0, 0, 1'b0); idle(2);
    start_word(8'h01); track(0, 0, 1'b0); idle(1);
    start_word(8'hF0); track(2, 3, 1'b0); idle(1);
    // load_valid held with 8'hFF throughout an 8'h0F transfer; FF is taken exactly in the done cycle.
    start_word(8'h0F); track(0, 0, 1'b1);
    start_word(8'hFF); track(0, 0, 1'b0); idle(2);
    start_word(8'h07); track(0, 0, 1'b0); idle(1);

    for (int i = 0; i < 4; i++) begin
      start_word(8'($urandom_range(0, 255)));
      track(int'($urandom_range(1, 5)), int'($urandom_range(0, 2)), 1'b0);
      idle(1);
    end

    // Reset in the middle of 8'hC3 while bit 4 is on the line.
    start_word(8'hC3);
    mb.load_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_sout", mb.sout, 1'b0);
    check("mid_valid", mb.sout_valid, 1'b0);
    check("mid_busy", mb.busy, 1'b0);
    check("mid_done", mb.done, 1'b0);
    check("mid_valid_l", lb.sout_valid, 1'b0);
    check("mid_busy_l", lb.busy, 1'b0);
    q_m.delete();
    q_l.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);

    start_word(8'h3C); track(0, 0, 1'b0); idle(2);

    check("q_m_empty", q_m.size(), 0);
    check("q_l_empty", q_l.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in/serial-out shift transmitter built from a register bank of D flip-flops.
- Accepts one WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock on a single serial line.
- Companion transmit end for the team's DFF-based storage and serial-capture blocks; it drives their d input.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 clears all state immediately.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word (high only in IDLE).
- load_data  input  WIDTH  word to transmit.
- shift_en  input  1  advance one bit this cycle when high; hold when low.
- sout  output  1  serial data out.
- sout_valid  output  1  sout carries a payload bit (or the parity bit).
- busy  output  1  high in SHIFT (and PARITY).
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1 once rst=1.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).
- IDLE:
  - load_ready=1, sout=0, sout_valid=0.
  - On an edge with load_valid=1: capture load_data into the shift register, clear the counter, go to SHIFT.
  - done is cleared in the cycle after its pulse.
- SHIFT:
  - sout is taken combinationally from the register head: bit WIDTH-1 if MSB_FIRST=1, else bit 0.
  - sout_valid=1, busy=1, load_ready=0.
  - On an edge with shift_en=1: shift the register toward the head (zero fill) and increment the counter.
  - On an edge with shift_en=0: register and counter hold, and sout holds its value.
  - When shift_en=1 with counter==WIDTH-1: go to IDLE (or PARITY with the feature) and register done=1 for exactly one cycle.
- Latency: handshake edge at cycle N. With shift_en held at 1, bit k appears in cycle N+1+k (k=0..WIDTH-1). done=1 and load_ready=1 in cycle N+WIDTH+1.
- Throughput: minimum one idle cycle between words; a new load can be accepted in the same cycle that done=1.
- load_valid while busy: ignored; no capture, no error.
- load_data is sampled only on the handshake edge; later changes have no effect.
- Reset mid-shift: remaining bits are abandoned, outputs return to reset values at once, and no done pulse is produced.
- Counter width: clog2(WIDTH); it never exceeds WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Even parity of the captured word is registered on the handshake edge.
  - After the last data bit (shift_en=1), the block enters PARITY and drives sout=parity with sout_valid=1, busy=1; this state also waits on shift_en.
  - On the next shift_en=1 edge it returns to IDLE with done=1.
  - Latency grows by one enabled cycle.
- Undefined: PARITY state and parity register are absent; transition is SHIFT to IDLE directly.

Test Plan:
- WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 in cycles N+1..N+8; done=1 only in N+9; load_ready=0 in N+1..N+8.
- MSB_FIRST=0, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 (LSB first; palindrome check). Load 8'h01 -> sout = 1,0,0,0,0,0,0,0.
- Load 8'hF0 with shift_en low for 3 cycles after bit 2 -> sout holds that bit value; total done delay = 8+3+1 cycles after the handshake.
- Assert load_valid with 8'hFF during an 8'h0F transfer -> transmission stays 8'h0F; a second word is accepted only in the cycle done=1.
- Drop rst to 0 at bit 4 of 8'hC3 -> sout=0, sout_valid=0, busy=0 immediately with no clock; no done; load_ready=1 after rst=1.
- PISO_PARITY_EN: 8'hA5 -> 9th bit = 0; 8'h07 -> 9th bit = 1; done in N+10.
